// File: rtl/systolic_block_param_if.sv
// Operand/result handshake bundle for systolic_block_param.
// master = operand/result buffer side, slave = the systolic tile.
interface systolic_block_param_if #(
  parameter int BIT_WIDTH = 16,
  parameter int ROWS      = 4,
  parameter int COLS      = 4
);
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic [ROWS*BIT_WIDTH-1:0] west_in;
  logic [COLS*BIT_WIDTH-1:0] north_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [COLS*BIT_WIDTH-1:0] out_row;
  logic [IDX_W-1:0]          out_row_idx;
  logic                      done;
  logic                      busy;

  modport master (output in_valid, in_last, west_in, north_in, out_ready,
                  input  in_ready, out_valid, out_row, out_row_idx, done, busy);
  modport slave  (input  in_valid, in_last, west_in, north_in, out_ready,
                  output in_ready, out_valid, out_row, out_row_idx, done, busy);
endinterface

// File: rtl/systolic_block_param.sv
// Output-stationary ROWS x COLS systolic matmul tile with input skew and row-serial drain.
// Define SYSTOLIC_SAT_EN to saturate results to BIT_WIDTH; otherwise results wrap.
module systolic_block_param #(
  parameter int BIT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int MAX_K      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  systolic_block_param_if.slave bus
);
  localparam int ACC_W = 2*BIT_WIDTH + $clog2(MAX_K);
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W = $clog2(ROWS + COLS);
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(ROWS + COLS - 2);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(ROWS - 1);
`ifdef SYSTOLIC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};
`endif

  // IDLE: wait beat | LOAD: stream K | FLUSH: empty pipe | DRAIN: present rows
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       out_valid_q;
  logic [COLS*BIT_WIDTH-1:0]  out_row_q;
  logic [IDX_W-1:0]           out_idx_q;
  logic                       done_q;

  logic                       in_ready;
  logic                       accept;
  logic                       first_beat;

  logic [ROWS-1:0][BIT_WIDTH-1:0]            a_src;
  logic [ROWS-1:0]                           av_src, af_src;
  logic [COLS-1:0][BIT_WIDTH-1:0]            b_src;
  logic [COLS-1:0]                           bv_src;
  logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0]  a_pe, b_pe;
  logic [ROWS-1:0][COLS-1:0]                 av_pe, af_pe, bv_pe;
  logic signed [ACC_W-1:0]                   acc_q [ROWS][COLS];

  logic [IDX_W-1:0]           idx_d;
  logic [COLS*BIT_WIDTH-1:0]  row_d;

  function automatic logic signed [ACC_W-1:0] mul_ext(
    input logic signed [BIT_WIDTH-1:0] a,
    input logic signed [BIT_WIDTH-1:0] b);
    logic signed [2*BIT_WIDTH-1:0] p;
    p = a * b;
    return {{(ACC_W-2*BIT_WIDTH){p[2*BIT_WIDTH-1]}}, p};
  endfunction

  function automatic logic [BIT_WIDTH-1:0] reduce(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC_WIDTH;
`ifdef SYSTOLIC_SAT_EN
    if (sh > SAT_MAX) return SAT_MAX[BIT_WIDTH-1:0];
    if (sh < SAT_MIN) return SAT_MIN[BIT_WIDTH-1:0];
`endif
    return sh[BIT_WIDTH-1:0];
  endfunction

  assign in_ready   = rst_n && (state_q == S_IDLE || state_q == S_LOAD);
  assign accept     = bus.in_valid && in_ready;
  assign first_beat = accept && (state_q == S_IDLE);

  // Row r enters r cycles late so A and B of the same k meet at every PE.
  for (genvar r = 0; r < ROWS; r++) begin : g_wskew
    if (r == 0) begin : g_direct
      assign a_src[r]  = bus.west_in[r*BIT_WIDTH +: BIT_WIDTH];
      assign av_src[r] = accept;
      assign af_src[r] = first_beat;
    end else begin : g_delay
      logic [BIT_WIDTH-1:0] d_q [r];
      logic                 v_q [r];
      logic                 f_q [r];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) begin
            d_q[i] <= '0;
            v_q[i] <= 1'b0;
            f_q[i] <= 1'b0;
          end
        end else begin
          d_q[0] <= bus.west_in[r*BIT_WIDTH +: BIT_WIDTH];
          v_q[0] <= accept;
          f_q[0] <= first_beat;
          for (int i = 1; i < r; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
            f_q[i] <= f_q[i-1];
          end
        end
      end
      assign a_src[r]  = d_q[r-1];
      assign av_src[r] = v_q[r-1];
      assign af_src[r] = f_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_nskew
    if (c == 0) begin : g_direct
      assign b_src[c]  = bus.north_in[c*BIT_WIDTH +: BIT_WIDTH];
      assign bv_src[c] = accept;
    end else begin : g_delay
      logic [BIT_WIDTH-1:0] d_q [c];
      logic                 v_q [c];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < c; i++) begin
            d_q[i] <= '0;
            v_q[i] <= 1'b0;
          end
        end else begin
          d_q[0] <= bus.north_in[c*BIT_WIDTH +: BIT_WIDTH];
          v_q[0] <= accept;
          for (int i = 1; i < c; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign b_src[c]  = d_q[c-1];
      assign bv_src[c] = v_q[c-1];
    end
  end

  // Eastward A forwarding registers; tap c-1 feeds PE column c.
  for (genvar r = 0; r < ROWS; r++) begin : g_arow
    assign a_pe[r][0]  = a_src[r];
    assign av_pe[r][0] = av_src[r];
    assign af_pe[r][0] = af_src[r];
    if (COLS > 1) begin : g_fwd
      logic [BIT_WIDTH-1:0] a_q  [COLS-1];
      logic                 av_q [COLS-1];
      logic                 af_q [COLS-1];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < COLS-1; i++) begin
            a_q[i]  <= '0;
            av_q[i] <= 1'b0;
            af_q[i] <= 1'b0;
          end
        end else begin
          a_q[0]  <= a_pe[r][0];
          av_q[0] <= av_pe[r][0];
          af_q[0] <= af_pe[r][0];
          for (int i = 1; i < COLS-1; i++) begin
            a_q[i]  <= a_q[i-1];
            av_q[i] <= av_q[i-1];
            af_q[i] <= af_q[i-1];
          end
        end
      end
      for (genvar c = 1; c < COLS; c++) begin : g_tap
        assign a_pe[r][c]  = a_q[c-1];
        assign av_pe[r][c] = av_q[c-1];
        assign af_pe[r][c] = af_q[c-1];
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bcol
    assign b_pe[0][c]  = b_src[c];
    assign bv_pe[0][c] = bv_src[c];
    if (ROWS > 1) begin : g_fwd
      logic [BIT_WIDTH-1:0] b_q  [ROWS-1];
      logic                 bv_q [ROWS-1];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < ROWS-1; i++) begin
            b_q[i]  <= '0;
            bv_q[i] <= 1'b0;
          end
        end else begin
          b_q[0]  <= b_pe[0][c];
          bv_q[0] <= bv_pe[0][c];
          for (int i = 1; i < ROWS-1; i++) begin
            b_q[i]  <= b_q[i-1];
            bv_q[i] <= bv_q[i-1];
          end
        end
      end
      for (genvar r = 1; r < ROWS; r++) begin : g_tap
        assign b_pe[r][c]  = b_q[r-1];
        assign bv_pe[r][c] = bv_q[r-1];
      end
    end
  end

  // The first beat's flag rides with A so each PE restarts its sum on arrival.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          acc_q[r][c] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (av_pe[r][c] && bv_pe[r][c])
            acc_q[r][c] <= af_pe[r][c] ? mul_ext(a_pe[r][c], b_pe[r][c])
                                       : acc_q[r][c] + mul_ext(a_pe[r][c], b_pe[r][c]);
    end
  end

  always_comb begin
    idx_d = '0;
    if (state_q == S_DRAIN && out_idx_q != IDX_LAST) idx_d = out_idx_q + IDX_W'(1);
    row_d = '0;
    for (int c = 0; c < COLS; c++)
      row_d[c*BIT_WIDTH +: BIT_WIDTH] = reduce(acc_q[idx_d][c]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (bus.in_last) begin
              state_q <= S_FLUSH;
              cnt_q   <= FLUSH_INIT;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (accept && bus.in_last) begin
            state_q <= S_FLUSH;
            cnt_q   <= FLUSH_INIT;
          end
        end
        S_FLUSH: begin
          if (cnt_q == '0) begin
            state_q     <= S_DRAIN;
            out_valid_q <= 1'b1;
            out_row_q   <= row_d;
            out_idx_q   <= idx_d;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (bus.out_ready) begin
            if (out_idx_q == IDX_LAST) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              out_row_q   <= '0;
              out_idx_q   <= '0;
              done_q      <= 1'b1;
            end else begin
              out_row_q <= row_d;
              out_idx_q <= idx_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_row     = out_row_q;
  assign bus.out_row_idx = out_idx_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q != S_IDLE);
endmodule
